// File: rtl/lsm_sequencer.sv
// rtl/lsm_sequencer.sv - load/store-multiple sequencer: moves mask-selected registers to/from consecutive memory words
module lsm_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int STRIDE   = 1,
    parameter int CNT_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_proc_rst,
    input  logic                i_start,
    input  logic                i_is_store,
    input  logic                i_descend,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [NUM_REGS-1:0] i_reg_mask,
    output logic                o_busy,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_xfer_count,
    output logic [ADDR_W-1:0]   o_final_addr,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_ready,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [REG_AW-1:0]   o_rf_raddr,
    input  logic [DATA_W-1:0]   i_rf_rdata,
    output logic                o_rf_wen,
    output logic [REG_AW-1:0]   o_rf_waddr,
    output logic [DATA_W-1:0]   o_rf_wdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_REQ  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [NUM_REGS-1:0] r_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_store;
    logic                r_desc;
    logic [REG_AW-1:0]   r_cur;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_req;
    logic                r_mem_we;
    logic                r_rf_wen;
    logic [REG_AW-1:0]   r_rf_waddr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic [CNT_W-1:0]    r_xfer_count;
    logic [ADDR_W-1:0]   r_final_addr;

    logic [REG_AW-1:0]   w_idx;
    logic [NUM_REGS-1:0] w_clear;
    logic [ADDR_W-1:0]   w_next_addr;

    // Later matches overwrite earlier ones, so scan direction sets the priority.
    always_comb begin
        w_idx = '0;
        if (r_desc) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (r_pend[i]) w_idx = REG_AW'(i);
        end else begin
            for (int i = NUM_REGS - 1; i >= 0; i--)
                if (r_pend[i]) w_idx = REG_AW'(i);
        end
    end

    assign w_clear     = NUM_REGS'(1) << w_idx;
    assign w_next_addr = r_desc ? (r_addr - ADDR_W'(STRIDE)) : (r_addr + ADDR_W'(STRIDE));

    always_ff @(posedge i_clk) begin
        if (i_proc_rst) begin
            r_state      <= S_IDLE;
            r_pend       <= '0;
            r_addr       <= '0;
            r_store      <= 1'b0;
            r_desc       <= 1'b0;
            r_cur        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_rf_wen     <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_xfer_count <= '0;
            r_final_addr <= '0;
        end else begin
            r_done   <= 1'b0;
            r_rf_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pend       <= i_reg_mask;
                        r_addr       <= i_base_addr;
                        r_store      <= i_is_store;
                        r_desc       <= i_descend;
                        r_xfer_count <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_pend == '0) begin
                        r_done       <= 1'b1;
                        r_final_addr <= r_addr;
                        r_state      <= S_DONE;
                    end else begin
                        r_cur     <= w_idx;
                        r_pend    <= r_pend & ~w_clear;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= r_store;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_store) begin
                            r_addr       <= w_next_addr;
                            r_xfer_count <= r_xfer_count + CNT_W'(1);
                            r_state      <= S_SCAN;
                        end else begin
                            r_rf_wen   <= 1'b1;
                            r_rf_waddr <= r_cur;
                            r_rf_wdata <= i_mem_rdata;
                            r_state    <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_addr       <= w_next_addr;
                    r_xfer_count <= r_xfer_count + CNT_W'(1);
                    r_state      <= S_SCAN;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_xfer_count = r_xfer_count;
    assign o_final_addr = r_final_addr;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = i_rf_rdata;
    assign o_rf_raddr   = r_cur;
    assign o_rf_wen     = r_rf_wen;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_lsm_sequencer.sv
// tb/tb_lsm_sequencer.sv - randomized self-checking bench for lsm_sequencer against a transfer-list model
module tb_lsm_sequencer;
    localparam int N      = 8;
    localparam int AW     = 3;
    localparam int ADDR_W = 16;
    localparam int DW     = 16;
    localparam int STRIDE = 1;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              proc_rst;
    logic              start;
    logic              is_store;
    logic              descend;
    logic [ADDR_W-1:0] base_addr;
    logic [N-1:0]      reg_mask;
    logic              busy, done;
    logic [CW-1:0]     xfer_count;
    logic [ADDR_W-1:0] final_addr;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;
    logic [AW-1:0]     rf_raddr;
    logic [DW-1:0]     rf_rdata;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    logic [DW-1:0]     rf  [N];
    logic [DW-1:0]     mem [65536];

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] q_maddr[$];
    logic              q_mwe[$];
    logic [DW-1:0]     q_mwdata[$];
    int                q_rfa[$];
    logic [DW-1:0]     q_rfd[$];
    int                wait_n = 0;
    int                wcnt = 0;
    int                unstable = 0;
    logic              prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    lsm_sequencer #(
        .NUM_REGS(N), .REG_AW(AW), .ADDR_W(ADDR_W), .DATA_W(DW), .STRIDE(STRIDE), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_proc_rst(proc_rst), .i_start(start), .i_is_store(is_store),
        .i_descend(descend), .i_base_addr(base_addr), .i_reg_mask(reg_mask),
        .o_busy(busy), .o_done(done), .o_xfer_count(xfer_count), .o_final_addr(final_addr),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_rf_raddr(rf_raddr),
        .i_rf_rdata(rf_rdata), .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata)
    );

    assign rf_rdata = rf[rf_raddr];

    // Memory and register-file responder; records every accepted transfer.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            q_rfa.push_back(int'(rf_waddr));
            q_rfd.push_back(rf_wdata);
            rf[rf_waddr] = rf_wdata;
        end
        if (mem_req === 1'b1) begin
            if (prev_wait && mem_addr !== prev_addr) unstable++;
            if (wcnt >= wait_n) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr];
                q_maddr.push_back(mem_addr);
                q_mwe.push_back(mem_we);
                q_mwdata.push_back(mem_wdata);
                if (mem_we) mem[mem_addr] = mem_wdata;
                wcnt = 0;
                prev_wait = 1'b0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = DW'($urandom);
                wcnt++;
                prev_wait = 1'b1;
                prev_addr = mem_addr;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = DW'($urandom);
            wcnt = 0;
            prev_wait = 1'b0;
        end
    end

    task automatic clear_obs();
        q_maddr.delete(); q_mwe.delete(); q_mwdata.delete();
        q_rfa.delete(); q_rfd.delete();
        unstable = 0;
    endtask

    task automatic run_op(input bit st, input bit ds, input logic [ADDR_W-1:0] base,
                          input logic [N-1:0] mask, input int wt, input string nm);
        int                idx[$];
        logic [ADDR_W-1:0] eaddr[$];
        logic [DW-1:0]     edata[$];
        logic [ADDR_W-1:0] a;
        int                n, i, cyc, ecyc;
        a = base;
        for (int k = 0; k < N; k++) begin
            i = ds ? (N - 1 - k) : k;
            if (mask[i]) begin
                idx.push_back(i);
                eaddr.push_back(a);
                edata.push_back(st ? rf[i] : mem[a]);
                a = ds ? a - ADDR_W'(STRIDE) : a + ADDR_W'(STRIDE);
            end
        end
        n = idx.size();
        ecyc = 2 + n * ((st ? 2 : 3) + wt);
        clear_obs();
        wait_n = wt;
        @(negedge clk);
        is_store = st; descend = ds; base_addr = base; reg_mask = mask; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        is_store = $urandom; descend = $urandom; base_addr = ADDR_W'($urandom); reg_mask = N'($urandom);
        cyc = 1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", nm, busy); end
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== ecyc) begin bad++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, cyc, ecyc); end
        total++;
        if (xfer_count !== CW'(n)) begin bad++; $display("FAIL %s xfer_count got=%0d want=%0d", nm, xfer_count, n); end
        total++;
        if (final_addr !== a) begin bad++; $display("FAIL %s final_addr got=%h want=%h", nm, final_addr, a); end
        total++;
        if (q_maddr.size() !== n) begin bad++; $display("FAIL %s mem_xfers got=%0d want=%0d", nm, q_maddr.size(), n); end
        for (int k = 0; k < n && k < q_maddr.size(); k++) begin
            total++;
            if (q_maddr[k] !== eaddr[k] || q_mwe[k] !== st || (st && q_mwdata[k] !== edata[k])) begin
                bad++;
                $display("FAIL %s mem_xfer[%0d] got=%h/%b/%h want=%h/%b/%h", nm, k,
                         q_maddr[k], q_mwe[k], q_mwdata[k], eaddr[k], st, edata[k]);
            end
        end
        total++;
        if (q_rfa.size() !== (st ? 0 : n)) begin bad++; $display("FAIL %s rf_writes got=%0d want=%0d", nm, q_rfa.size(), st ? 0 : n); end
        for (int k = 0; !st && k < n && k < q_rfa.size(); k++) begin
            total++;
            if (q_rfa[k] !== idx[k] || q_rfd[k] !== edata[k]) begin
                bad++;
                $display("FAIL %s rf_write[%0d] got=R%0d/%h want=R%0d/%h", nm, k, q_rfa[k], q_rfd[k], idx[k], edata[k]);
            end
        end
        total++;
        if (unstable !== 0) begin bad++; $display("FAIL %s req_stability got=%0d want=0", nm, unstable); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || xfer_count !== CW'(n) || final_addr !== a) begin
            bad++;
            $display("FAIL %s after_done got=%b/%b/%0d/%h want=0/0/%0d/%h", nm, done, busy, xfer_count, final_addr, n, a);
        end
    endtask

    task automatic test_reset();
        proc_rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, mem_req, mem_we, rf_wen} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, mem_req, mem_we, rf_wen});
        end
        total++;
        if (xfer_count !== '0 || final_addr !== '0 || mem_addr !== '0) begin
            bad++; $display("FAIL reset_data got=%0d/%h/%h want=0/0000/0000", xfer_count, final_addr, mem_addr);
        end
        total++;
        if (rf_raddr !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            bad++; $display("FAIL reset_rf got=%0d/%0d/%h want=0/0/0000", rf_raddr, rf_waddr, rf_wdata);
        end
        proc_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_example();
        run_op(1'b1, 1'b0, 16'h0040, 8'b1010_0101, 0, "store_a5");
        total++;
        if (final_addr !== 16'h0044 || xfer_count !== 4'd4) begin
            bad++; $display("FAIL store_a5_const got=%h/%0d want=0044/4", final_addr, xfer_count);
        end
    endtask

    task automatic test_load_descend();
        run_op(1'b0, 1'b1, 16'h0100, 8'hFF, 0, "load_ff_desc");
        total++;
        if (final_addr !== 16'h00F8 || q_rfa.size() !== 8 || q_rfa[0] !== 7 || q_maddr[7] !== 16'h00F9) begin
            bad++; $display("FAIL load_ff_desc_const got=%h/%0d want=00f8/8", final_addr, q_rfa.size());
        end
    endtask

    task automatic test_empty_mask();
        run_op(1'b1, 1'b0, 16'h1234, 8'h00, 0, "empty");
        total++;
        if (final_addr !== 16'h1234 || q_maddr.size() !== 0) begin
            bad++; $display("FAIL empty_const got=%h/%0d want=1234/0", final_addr, q_maddr.size());
        end
    endtask

    task automatic test_wait_states();
        run_op(1'b0, 1'b0, 16'h0300, 8'h03, 3, "wait3_load");
    endtask

    task automatic test_wrap();
        run_op(1'b1, 1'b0, 16'hFFFE, 8'h0F, 0, "wrap");
        total++;
        if (q_maddr.size() !== 4 || q_maddr[2] !== 16'h0000 || final_addr !== 16'h0002) begin
            bad++; $display("FAIL wrap_const got=%0d/%h want=4/0002", q_maddr.size(), final_addr);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        clear_obs();
        wait_n = 3;
        @(negedge clk);
        is_store = 1'b0; descend = 1'b0; base_addr = 16'h0200; reg_mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(q_rfa.size() == 1 && mem_req === 1'b1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 200) begin bad++; $display("FAIL midrst_reach got=timeout want=second_req"); end
        proc_rst = 1'b1;
        @(negedge clk);
        proc_rst = 1'b0;
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || rf_wen !== 1'b0) begin
            bad++; $display("FAIL midrst_idle got=%b%b%b want=000", busy, mem_req, rf_wen);
        end
        repeat (10) @(negedge clk);
        total++;
        if (q_rfa.size() !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_quiet got=%0d/%b want=1/0", q_rfa.size(), busy);
        end
        run_op(1'b0, 1'b0, 16'h0400, 8'h81, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic exp_busy[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_done[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        is_store = 1'b1; descend = 1'b0; base_addr = 16'h0777; reg_mask = 8'h00; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (busy !== exp_busy[c] || done !== exp_done[c]) begin
                bad++; $display("FAIL b2b_cycle%0d got=%b%b want=%b%b", c + 1, busy, done, exp_busy[c], exp_done[c]);
            end
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || final_addr !== 16'h0777 || xfer_count !== '0) begin
            bad++; $display("FAIL b2b_end got=%b/%h/%0d want=0/0777/0", busy, final_addr, xfer_count);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++)
            run_op(1'($urandom), 1'($urandom), ADDR_W'($urandom), N'($urandom), int'($urandom_range(0, 2)), "random");
    endtask

    initial begin
        proc_rst = 1'b1; start = 1'b0; is_store = 1'b0; descend = 1'b0;
        base_addr = '0; reg_mask = '0; mem_ready = 1'b0; mem_rdata = '0;
        for (int k = 0; k < N; k++) rf[k] = DW'($urandom);
        for (int k = 0; k < 65536; k++) mem[k] = DW'($urandom);
        test_reset();
        test_store_example();
        test_load_descend();
        test_empty_mask();
        test_wait_states();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
